// File: rtl/mem_xfer_if.sv
// Bundle between the load/store control FSM and its requester/bus side.
//   master : decoder/memory side; drives start, is_store, para1, para2, mfc
//   slave  : mem_xfer_fsm; drives the memory handshake (en, rw), the
//            MAR/MDR controls, the one-hot reg_rd/reg_wr, busy, done, err
interface mem_xfer_if #(
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = 6
) ();
   logic                start;
   logic                is_store;
   logic [IDX_W-1:0]    para1;
   logic [IDX_W-1:0]    para2;
   logic                mfc;
   logic                en;
   logic                rw;
   logic                mar_load;
   logic                mdr_load_bus;
   logic                mdr_load_mem;
   logic                mdr_drive;
   logic [NUM_REGS-1:0] reg_rd;
   logic [NUM_REGS-1:0] reg_wr;
   logic                busy;
   logic                done;
   logic                err;

   modport master (
      output start, is_store, para1, para2, mfc,
      input  en, rw, mar_load, mdr_load_bus, mdr_load_mem, mdr_drive,
             reg_rd, reg_wr, busy, done, err
   );

   modport slave (
      input  start, is_store, para1, para2, mfc,
      output en, rw, mar_load, mdr_load_bus, mdr_load_mem, mdr_drive,
             reg_rd, reg_wr, busy, done, err
   );
endinterface

// File: rtl/mem_xfer_fsm.sv
// Load/store control FSM: LOAD moves mem[reg[a]] -> reg[d], STORE moves
// reg[d] -> mem[reg[a]], with a = para1 and d = para2 latched on start.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   xif  - mem_xfer_if.slave: start/operands/mfc in; memory handshake,
//          MAR/MDR controls, one-hot reg_rd/reg_wr, busy/done/err out
// Optional: define MFC_TIMEOUT_EN to bound the mfc rise and fall waits to
// TIMEOUT cycles each; expiry ends the transfer through ERR.
//
// state   | meaning
// IDLE    | waiting for start; operands latched and indices checked here
// ADDR    | address register onto bus
// MARLD   | address register onto bus, bus -> MAR
// RREQ    | memory read request
// RWAIT   | read in flight, memory -> MDR until mfc rises
// RREL    | MDR onto bus, en released, wait for mfc to fall
// WB      | MDR onto bus, bus -> data register
// WDATA   | data register onto bus, bus -> MDR
// WREQ    | memory write request
// WWAIT   | write in flight until mfc rises
// WREL    | en released, wait for mfc to fall
// DONE    | completion pulse
// ERR     | completion pulse with err (bad index or mfc timeout)
module mem_xfer_fsm #(
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = 6,
   parameter int TIMEOUT  = 15,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        rst,
   mem_xfer_if.slave   xif
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_ADDR  = 4'd1;
   localparam logic [3:0] S_MARLD = 4'd2;
   localparam logic [3:0] S_RREQ  = 4'd3;
   localparam logic [3:0] S_RWAIT = 4'd4;
   localparam logic [3:0] S_RREL  = 4'd5;
   localparam logic [3:0] S_WB    = 4'd6;
   localparam logic [3:0] S_WDATA = 4'd7;
   localparam logic [3:0] S_WREQ  = 4'd8;
   localparam logic [3:0] S_WWAIT = 4'd9;
   localparam logic [3:0] S_WREL  = 4'd10;
   localparam logic [3:0] S_DONE  = 4'd11;
   localparam logic [3:0] S_ERR   = 4'd12;

   if (TIMEOUT < 1 || (TIMEOUT >> CNT_W) != 0) begin : g_bad_cfg
      $error("mem_xfer_fsm: TIMEOUT must be >= 1 and fit in CNT_W bits");
   end

   logic [3:0]          state_q, state_d;
   logic [IDX_W-1:0]    a_q, a_d, d_q, d_d;
   logic                st_q, st_d;
   logic                tmo;
   logic [NUM_REGS-1:0] a_oh, d_oh;

`ifdef MFC_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_wait;

   assign in_wait = (state_q == S_RWAIT) || (state_q == S_RREL) ||
                    (state_q == S_WWAIT) || (state_q == S_WREL);
   // Count restarts on every state change, so each wait gets its own budget.
   assign cnt_d   = (in_wait && state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
   assign tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      st_d    = st_q;
      case (state_q)
         S_IDLE: if (xif.start) begin
            a_d     = xif.para1;
            d_d     = xif.para2;
            st_d    = xif.is_store;
            state_d = (xif.para1 < IDX_W'(NUM_REGS) && xif.para2 < IDX_W'(NUM_REGS))
                      ? S_ADDR : S_ERR;
         end
         S_ADDR:  state_d = S_MARLD;
         S_MARLD: state_d = st_q ? S_WDATA : S_RREQ;
         S_RREQ:  state_d = S_RWAIT;
         S_RWAIT: if (xif.mfc) state_d = S_RREL;  else if (tmo) state_d = S_ERR;
         S_RREL:  if (!xif.mfc) state_d = S_WB;   else if (tmo) state_d = S_ERR;
         S_WB:    state_d = S_DONE;
         S_WDATA: state_d = S_WREQ;
         S_WREQ:  state_d = S_WWAIT;
         S_WWAIT: if (xif.mfc) state_d = S_WREL;  else if (tmo) state_d = S_ERR;
         S_WREL:  if (!xif.mfc) state_d = S_DONE; else if (tmo) state_d = S_ERR;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state (and next operands) and
   // registered, so each output is high exactly while the FSM sits in the
   // corresponding state and comes straight off a flop.
   assign a_oh = NUM_REGS'(1) << a_d;
   assign d_oh = NUM_REGS'(1) << d_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= S_IDLE;
         a_q              <= '0;
         d_q              <= '0;
         st_q             <= 1'b0;
         xif.en           <= 1'b0;
         xif.rw           <= 1'b0;
         xif.mar_load     <= 1'b0;
         xif.mdr_load_bus <= 1'b0;
         xif.mdr_load_mem <= 1'b0;
         xif.mdr_drive    <= 1'b0;
         xif.reg_rd       <= '0;
         xif.reg_wr       <= '0;
         xif.busy         <= 1'b0;
         xif.done         <= 1'b0;
         xif.err          <= 1'b0;
      end else begin
         state_q          <= state_d;
         a_q              <= a_d;
         d_q              <= d_d;
         st_q             <= st_d;
         xif.en           <= (state_d == S_RREQ) || (state_d == S_RWAIT) ||
                             (state_d == S_WREQ) || (state_d == S_WWAIT);
         xif.rw           <= (state_d == S_RREQ) || (state_d == S_RWAIT);
         xif.mar_load     <= (state_d == S_MARLD);
         xif.mdr_load_bus <= (state_d == S_WDATA);
         xif.mdr_load_mem <= (state_d == S_RWAIT);
         xif.mdr_drive    <= (state_d == S_RREL) || (state_d == S_WB);
         xif.reg_rd       <= (state_d == S_ADDR || state_d == S_MARLD) ? a_oh :
                             (state_d == S_WDATA) ? d_oh : '0;
         xif.reg_wr       <= (state_d == S_WB) ? d_oh : '0;
         xif.busy         <= (state_d != S_IDLE);
         xif.done         <= (state_d == S_DONE) || (state_d == S_ERR);
         xif.err          <= (state_d == S_ERR);
      end
   end

endmodule

// File: tb/tb_mem_xfer_fsm.sv
module tb_mem_xfer_fsm;
   localparam int NR  = 4;
   localparam int IW  = 6;
   localparam int TMO = 15;
   localparam int CW  = 4;
   localparam int W   = 9 + 2 * NR;
`ifdef MFC_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_xfer_if #(.NUM_REGS(NR), .IDX_W(IW)) xif ();

   mem_xfer_fsm #(.NUM_REGS(NR), .IDX_W(IW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .xif (xif)
   );

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   logic [W-1:0] exp_q[$];

   always @(negedge clk) if (xif.done === 1'b1) done_cnt++;

   function automatic logic [W-1:0] obs();
      return {xif.busy, xif.done, xif.err, xif.en, xif.rw, xif.mar_load,
              xif.mdr_load_bus, xif.mdr_load_mem, xif.mdr_drive, xif.reg_rd, xif.reg_wr};
   endfunction

   function automatic logic [W-1:0] vec(input bit b, dn, er, e, r_w, mar, mlb, mlm, mdv,
                                        input logic [NR-1:0] rd, wr);
      return {b, dn, er, e, r_w, mar, mlb, mlm, mdv, rd, wr};
   endfunction

   // Expected per-cycle outputs of one transfer; entry 0 is the IDLE cycle
   // in which start is presented, entry k is k cycles after that edge.
   // r = extra mfc-low cycles in the wait, f = extra mfc-high cycles in release.
   function automatic void build_trace(input bit st, input int a, d, r, f);
      logic [NR-1:0] ao, dd;
      int nw, nr;
      exp_q.delete();
      exp_q.push_back('0);
      if (a >= NR || d >= NR) begin
         exp_q.push_back(vec(1,1,1,0,0,0,0,0,0,'0,'0));
         return;
      end
      ao = '0; ao[a] = 1'b1;
      dd = '0; dd[d] = 1'b1;
      nw = (TMO_ON && r >= TMO) ? TMO : r + 1;
      nr = (TMO_ON && f >= TMO) ? TMO : f + 1;
      exp_q.push_back(vec(1,0,0,0,0,0,0,0,0,ao,'0));
      exp_q.push_back(vec(1,0,0,0,0,1,0,0,0,ao,'0));
      if (!st) begin
         exp_q.push_back(vec(1,0,0,1,1,0,0,0,0,'0,'0));
         for (int i = 0; i < nw; i++) exp_q.push_back(vec(1,0,0,1,1,0,0,1,0,'0,'0));
         if (TMO_ON && r >= TMO) begin exp_q.push_back(vec(1,1,1,0,0,0,0,0,0,'0,'0)); return; end
         for (int i = 0; i < nr; i++) exp_q.push_back(vec(1,0,0,0,0,0,0,0,1,'0,'0));
         if (TMO_ON && f >= TMO) begin exp_q.push_back(vec(1,1,1,0,0,0,0,0,0,'0,'0)); return; end
         exp_q.push_back(vec(1,0,0,0,0,0,0,0,1,'0,dd));
      end else begin
         exp_q.push_back(vec(1,0,0,0,0,0,1,0,0,dd,'0));
         exp_q.push_back(vec(1,0,0,1,0,0,0,0,0,'0,'0));
         for (int i = 0; i < nw; i++) exp_q.push_back(vec(1,0,0,1,0,0,0,0,0,'0,'0));
         if (TMO_ON && r >= TMO) begin exp_q.push_back(vec(1,1,1,0,0,0,0,0,0,'0,'0)); return; end
         for (int i = 0; i < nr; i++) exp_q.push_back(vec(1,0,0,0,0,0,0,0,0,'0,'0));
         if (TMO_ON && f >= TMO) begin exp_q.push_back(vec(1,1,1,0,0,0,0,0,0,'0,'0)); return; end
      end
      exp_q.push_back(vec(1,1,0,0,0,0,0,0,0,'0,'0));
   endfunction

   // Called in an IDLE cycle (#1 after a rising edge). Presents start, then
   // walks the expected trace, scrambling start/operands while busy, and
   // returns in the IDLE cycle that follows done.
   task automatic run_xfer(input bit st, input int a, d, r, f, early, input bit hold,
                           input string tag);
      int w, lo, hi, n;
      logic [W-1:0] got;
      build_trace(st, a, d, r, f);
      n  = exp_q.size();
      w  = st ? 5 : 4;
      lo = w + r - early;
      hi = w + r + f;
      if (a >= NR || d >= NR) begin lo = n + 10; hi = n + 10; end
      xif.start    = 1'b1;
      xif.is_store = st;
      xif.para1    = IW'(a);
      xif.para2    = IW'(d);
      xif.mfc      = 1'b0;
      n_checks++;
      got = obs();
      if (got !== exp_q[0]) begin
         n_errors++;
         $display("FAIL %s idle-before-start: got %h expected %h", tag, got, exp_q[0]);
      end
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         xif.mfc = (k >= lo && k <= hi);
         if (k < n) begin
            xif.start    = hold ? 1'b1 : 1'($urandom_range(0, 1));
            xif.is_store = 1'($urandom_range(0, 1));
            xif.para1    = IW'($urandom);
            xif.para2    = IW'($urandom);
            n_checks++;
            got = obs();
            if (got !== exp_q[k]) begin
               n_errors++;
               $display("FAIL %s cycle %0d: got %h expected %h", tag, k, got, exp_q[k]);
            end
         end else begin
            xif.start = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      logic [W-1:0] got;
      rst = 1'b1; xif.start = 1'b0; xif.is_store = 1'b0;
      xif.para1 = '0; xif.para2 = '0; xif.mfc = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_checks++; got = obs();
      if (got !== '0) begin n_errors++; $display("FAIL reset_async: got %h expected 0", got); end
      xif.start = 1'b1; xif.para1 = 6'd1; xif.para2 = 6'd2;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; got = obs();
         if (got !== '0) begin n_errors++; $display("FAIL reset_hold: got %h expected 0", got); end
      end
      rst = 1'b1; xif.start = 1'b0;
      @(posedge clk); #1;
      n_checks++; got = obs();
      if (got !== '0) begin n_errors++; $display("FAIL reset_release: got %h expected 0", got); end
   endtask

   task automatic test_load();
      run_xfer(1'b0, 1, 3, 0, 0, 0, 1'b0, "load_basic");
      for (int i = 0; i < 6; i++) begin
         int r = $urandom_range(0, 6);
         run_xfer(1'b0, $urandom_range(0, NR-1), $urandom_range(0, NR-1), r,
                  $urandom_range(0, 4), (r == 0) ? $urandom_range(0, 2) : 0, 1'b0, "load_rand");
      end
   endtask

   task automatic test_store();
      run_xfer(1'b1, 0, 2, 4, 0, 0, 1'b0, "store_basic");
      for (int i = 0; i < 6; i++) begin
         int r = $urandom_range(0, 6);
         run_xfer(1'b1, $urandom_range(0, NR-1), $urandom_range(0, NR-1), r,
                  $urandom_range(0, 4), (r == 0) ? $urandom_range(0, 2) : 0, 1'b0, "store_rand");
      end
   endtask

   task automatic test_bad_index();
      run_xfer(1'b0, 1, 4, 0, 0, 0, 1'b0, "err_para2");
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 1) == 1)
            run_xfer(1'($urandom_range(0, 1)), $urandom_range(NR, 63), $urandom_range(0, 63),
                     0, 0, 0, 1'b0, "err_para1_rand");
         else
            run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, NR-1), $urandom_range(NR, 63),
                     0, 0, 0, 1'b0, "err_para2_rand");
      end
   endtask

   task automatic test_reset_midxfer();
      logic [W-1:0] got, want;
      xif.start = 1'b1; xif.is_store = 1'b0; xif.para1 = 6'd2; xif.para2 = 6'd1; xif.mfc = 1'b0;
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; xif.start = 1'b0; end
      want = vec(1,0,0,1,1,0,0,1,0,'0,'0);
      n_checks++; got = obs();
      if (got !== want) begin n_errors++; $display("FAIL midxfer_rwait: got %h expected %h", got, want); end
      #2 rst = 1'b0;
      #1;
      n_checks++; got = obs();
      if (got !== '0) begin n_errors++; $display("FAIL midxfer_async_clear: got %h expected 0", got); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; got = obs();
      if (got !== '0) begin n_errors++; $display("FAIL midxfer_after_release: got %h expected 0", got); end
      run_xfer(1'b0, 3, 0, 1, 1, 0, 1'b0, "midxfer_recover");
   endtask

   task automatic test_back_to_back();
      int d0;
      logic [W-1:0] got;
      d0 = done_cnt;
      run_xfer(1'b0, $urandom_range(0, NR-1), $urandom_range(0, NR-1), $urandom_range(0, 3),
               $urandom_range(0, 2), 0, 1'b1, "b2b_first");
      run_xfer(1'b0, $urandom_range(0, NR-1), $urandom_range(0, NR-1), $urandom_range(0, 3),
               $urandom_range(0, 2), 0, 1'b1, "b2b_second");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; got = obs();
         if (got !== '0) begin n_errors++; $display("FAIL b2b_idle_tail: got %h expected 0", got); end
      end
      n_checks++;
      if (done_cnt - d0 !== 2) begin
         n_errors++;
         $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt - d0);
      end
   endtask

`ifdef MFC_TIMEOUT_EN
   task automatic test_timeout();
      run_xfer(1'b0, 1, 2, TMO + 5, 0, 0, 1'b0, "tmo_load_rise");
      run_xfer(1'b1, 0, 3, TMO + 2, 0, 0, 1'b0, "tmo_store_rise");
      run_xfer(1'b0, 2, 1, 1, TMO + 4, 0, 1'b0, "tmo_load_fall");
      run_xfer(1'b1, 3, 3, 0, TMO + 1, 0, 1'b0, "tmo_store_fall");
      run_xfer(1'b0, 1, 1, TMO - 1, 0, 0, 1'b0, "tmo_load_edge_ok");
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_store();
      test_bad_index();
      test_reset_midxfer();
      test_back_to_back();
`ifdef MFC_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
